rice_core_muldiv_unit: RTL and testbench
========================================

Name: rice_core_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide execution unit, instantiated inside the EX stage next to the LSU and CSR read/write unit.
- Uses the same valid/done contract as those units: the EX stage holds i_valid and stalls while i_valid && !o_done.
- The EX stage takes o_result into its result register in the o_done cycle.
- Throughput/area trade-off is set by the BITS_PER_CYCLE parameter.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
BITS_PER_CYCLE, 1, quotient/multiplier bits processed per cycle; power of two, divides XLEN (1, 2, 4, 8).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  reset; asynchronous, active-low.
i_valid  input  1  an M-extension instruction is in EX (id_result.valid && op is muldiv); held until o_done.
i_flush  input  1  abort the current operation (pipeline flush or !i_enable).
i_operation  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
i_rs1_value  input  XLEN  forwarded rs1 value (dividend / multiplicand).
i_rs2_value  input  XLEN  forwarded rs2 value (divisor / multiplier).
o_done  output  1  one-cycle pulse: o_result valid this cycle.
o_result  output  XLEN  result; registered.
o_busy  output  1  state != IDLE.

Behaviour:
Reset and constants:
- Reset (async, any time, including mid-operation): state IDLE, o_done 0, o_result 0, o_busy 0, internal counter and accumulators 0.
- N = XLEN / BITS_PER_CYCLE.

States: IDLE, CALC, DONE.
- IDLE, i_valid && !i_flush:
  - Capture operation, operand magnitudes and result sign.
  - Signedness per op: MULH both signed; MULHSU rs1 signed; DIV/REM both signed; MUL sign-agnostic (low half).
  - Special divide cases go to DONE with the result preset:
    - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
    - Signed overflow, rs1 = 1<<(XLEN-1) and rs2 = -1: DIV gives rs1; REM gives 0.
  - Otherwise load counter = N and go to CALC.
- CALC:
  - Per cycle, perform BITS_PER_CYCLE steps.
  - Multiply steps: shift-add on a 2*XLEN-bit product.
  - Divide steps: restoring division, remainder XLEN+1 bits, quotient shifted in LSB-first.
  - Decrement the counter. When the counter reaches 1, go to DONE.
  - Sign correction (two's-complement negate) is applied on the CALC->DONE transition.
  - Quotient is negated if sign(rs1) != sign(rs2). Remainder takes the sign of rs1.
  - o_result selection: low half for MUL; high half for MULH/MULHSU/MULHU; quotient or remainder otherwise.
- DONE:
  - o_done = 1 for exactly this cycle.
  - Next state IDLE unconditionally.
  - i_valid in the following cycle is a new instruction, so back-to-back ops start with no idle gap beyond DONE->IDLE.

Latency, from the cycle i_valid is first sampled in IDLE (cycle 0):
- Normal ops: o_done in cycle N+1. At XLEN=32, BPC=1 that is cycle 33; at BPC=4 it is cycle 9.
- Special divide cases: o_done in cycle 1.

Flush, other inputs and output holding:
- i_flush in any state: next state IDLE, no o_done. i_flush wins over a simultaneous start.
- i_flush in the DONE cycle does not suppress o_done; the EX stage discards the result.
- Operands and operation are sampled only in IDLE. Changes on the inputs during CALC are ignored.
- o_result holds its value until the next DONE.
- Arithmetic is exact modulo 2^XLEN. No exceptions are raised.

Test Plan:
- XLEN=32, BPC=1: MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_done exactly at cycle 33, single-cycle pulse, o_busy high cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100%7 -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9%2 -> 0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF and REM 5%0 -> 5, each with o_done at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same operands -> 0, both at cycle 1.
- Start DIVU, assert i_flush at cycle 10 -> no o_done, o_busy 0 next cycle; immediately issue MUL 3 x 4 -> 12 at cycle 33 of the new op. Then async reset at cycle 5 of another op -> all outputs 0 at once.
- BPC=4 and XLEN=64, BPC=8: random signed/unsigned ops back-to-back against a reference model -> exact match; o_done at cycle 9 and 9 respectively.

Source files
------------

// File: rtl/rice_core_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Latency XLEN/BITS_PER_CYCLE+1 cycles (1 for divide-by-zero/overflow); i_valid held until o_done.
module rice_core_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [2:0]      i_operation,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   b_q;
    logic [CW-1:0]     cnt_q;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              start;

    always_comb begin
        is_div   = i_operation[2];
        a_signed = (i_operation == 3'd1) || (i_operation == 3'd2) ||
                   (i_operation == 3'd4) || (i_operation == 3'd6);
        b_signed = (i_operation == 3'd1) || (i_operation == 3'd4) || (i_operation == 3'd6);
        a_neg    = a_signed && i_rs1_value[XLEN-1];
        b_neg    = b_signed && i_rs2_value[XLEN-1];
        a_mag    = a_neg ? -i_rs1_value : i_rs1_value;
        b_mag    = b_neg ? -i_rs2_value : i_rs2_value;
        div_zero = is_div && (i_rs2_value == '0);
        div_ovf  = is_div && !i_operation[0] &&
                   (i_rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_value == '1);
        special  = div_zero || div_ovf;
        // operation[1] selects remainder within the divide group
        if (i_operation[1])
            special_res = div_zero ? i_rs1_value : '0;
        else
            special_res = div_zero ? '1 : i_rs1_value;
        start = (state_q == IDLE) && i_valid && !i_flush;
    end

    logic [XLEN-1:0]   acc_s, lo_s;
    logic [XLEN:0]     shifted, trial, sum;

    always_comb begin
        acc_s   = acc_q;
        lo_s    = lo_q;
        shifted = '0;
        trial   = '0;
        sum     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                shifted = {acc_s, lo_s[XLEN-1]};
                trial   = shifted - {1'b0, b_q};
                if (!trial[XLEN]) begin
                    acc_s = trial[XLEN-1:0];
                    lo_s  = {lo_s[XLEN-2:0], 1'b1};
                end else begin
                    acc_s = shifted[XLEN-1:0];
                    lo_s  = {lo_s[XLEN-2:0], 1'b0};
                end
            end else begin
                sum   = {1'b0, acc_s} + (lo_s[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
                acc_s = sum[XLEN:1];
                lo_s  = {sum[0], lo_s[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, calc_res;

    always_comb begin
        prod   = {acc_s, lo_s};
        prod_f = neg_q ? -prod : prod;
        quo_f  = neg_q ? -lo_s : lo_s;
        rem_f  = rneg_q ? -acc_s : acc_s;
        case (op_q)
            3'd0:                calc_res = prod_f[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    calc_res = prod_f[2*XLEN-1:XLEN];
            3'd4, 3'd5:          calc_res = quo_f;
            default:             calc_res = rem_f;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = special ? DONE : CALC;
            CALC: begin
                if (i_flush)               state_d = IDLE;
                else if (cnt_q == CW'(1))  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            o_result <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= i_operation;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                acc_q  <= '0;
                lo_q   <= is_div ? a_mag : b_mag;
                b_q    <= is_div ? b_mag : a_mag;
                cnt_q  <= CW'(N);
                if (special) o_result <= special_res;
            end else if (state_q == CALC && !i_flush) begin
                acc_q <= acc_s;
                lo_q  <= lo_s;
                cnt_q <= cnt_q - CW'(1);
                // sign correction is folded into the final step
                if (cnt_q == CW'(1)) o_result <= calc_res;
            end
        end
    end

    assign o_done = (state_q == DONE);
    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_rice_core_muldiv_unit.sv
// Bench for rice_core_muldiv_unit: directed checks at XLEN=32/BPC=1, random ops at
// XLEN=32/BPC=4 and XLEN=64/BPC=8, scoreboarded against a behavioural reference.
module tb_rice_core_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, f0, done0, busy0;
    logic [2:0]  op0;
    logic [31:0] a0, b0, r0;
    logic        v1, f1, done1, busy1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, r1;
    logic        v2, f2, done2, busy2;
    logic [2:0]  op2;
    logic [63:0] a2, b2, r2;

    rice_core_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .i_flush(f0), .i_operation(op0),
        .i_rs1_value(a0), .i_rs2_value(b0), .o_done(done0), .o_result(r0), .o_busy(busy0));
    rice_core_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_flush(f1), .i_operation(op1),
        .i_rs1_value(a1), .i_rs2_value(b1), .o_done(done1), .o_result(r1), .o_busy(busy1));
    rice_core_muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(8)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .i_flush(f2), .i_operation(op2),
        .i_rs1_value(a2), .i_rs2_value(b2), .o_done(done2), .o_result(r2), .o_busy(busy2));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic f, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        case (sel)
            0:       begin v0 = v; f0 = f; op0 = op; a0 = a[31:0]; b0 = b[31:0]; end
            1:       begin v1 = v; f1 = f; op1 = op; a1 = a[31:0]; b1 = b[31:0]; end
            default: begin v2 = v; f2 = f; op2 = op; a2 = a;       b2 = b;       end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int sel);
        case (sel)
            0:       return {32'd0, r0};
            1:       return {32'd0, r1};
            default: return r2;
        endcase
    endfunction

    // Behavioural RV M-extension semantics using wide signed arithmetic
    function automatic logic [63:0] ref_op(input int xl, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0]          m;
        logic signed [129:0]  as_v, au_v, bs_v, bu_v, r;
        m    = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        au_v = $signed({66'd0, a & m});
        bu_v = $signed({66'd0, b & m});
        if (xl == 32) begin
            as_v = $signed({{98{a[31]}}, a[31:0]});
            bs_v = $signed({{98{b[31]}}, b[31:0]});
        end else begin
            as_v = $signed({{66{a[63]}}, a});
            bs_v = $signed({{66{b[63]}}, b});
        end
        r = '0;
        case (op)
            3'd0: r = as_v * bs_v;
            3'd1: r = (as_v * bs_v) >>> xl;
            3'd2: r = (as_v * bu_v) >>> xl;
            3'd3: r = (au_v * bu_v) >>> xl;
            default: begin
                if ((b & m) == 64'd0) begin
                    if (op[1]) r = au_v;
                    else       r = '1;
                end else begin
                    case (op)
                        3'd4:    r = as_v / bs_v;
                        3'd5:    r = au_v / bu_v;
                        3'd6:    r = as_v % bs_v;
                        default: r = au_v % bu_v;
                    endcase
                end
            end
        endcase
        return r[63:0] & m;
    endfunction

    // Issue one op in the current (IDLE) cycle, wait for o_done, compare result/latency/busy
    task automatic run_op(input int sel, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat,
                          input string tag);
        int          cyc;
        int          busy_cnt;
        logic        seen;
        logic [63:0] e;
        drive(sel, 1'b1, 1'b0, op, a, b);
        sb_q.push_back(exp);
        seen     = 1'b0;
        busy_cnt = 0;
        cyc      = 0;
        while (!seen && cyc <= 100) begin
            @(negedge clk);
            if (get_busy(sel)) busy_cnt++;
            if (get_done(sel)) begin
                seen = 1'b1;
                e    = sb_q.pop_front();
                check({tag, " result"}, get_res(sel), e);
                check({tag, " latency"}, 64'(cyc), 64'(lat));
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_checks++;
        assert (seen) else begin
            n_errors++;
            $error("FAIL %s timeout: observed no o_done expected o_done by cycle %0d", tag, lat);
            void'(sb_q.pop_front());
        end
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat));
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, op, a, b);
    endtask

    task automatic run_random(input int sel, input int xl, input int count);
        logic [63:0] m, mn, a, b, exp;
        logic [2:0]  op;
        int          lat;
        m  = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        mn = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        for (int k = 0; k < count; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom} & m;
            b  = {$urandom, $urandom} & m;
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       begin a = mn; b = m; end
                2:       b = 64'($urandom_range(1, 20));
                3:       a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            exp = ref_op(xl, op, a, b);
            lat = (op[2] && (b == 64'd0 || (!op[0] && a == mn && b == m))) ? 1 : 9;
            run_op(sel, op, a, b, exp, lat, $sformatf("rnd x%0d #%0d op%0d", xl, k, op));
        end
    endtask

    initial begin
        logic nodone;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive(2, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset done", {63'd0, done0}, 64'd0);
        check("reset result", {32'd0, r0}, 64'd0);
        check("reset busy", {63'd0, busy0}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, "MUL 7*-3");
        @(negedge clk);
        check("MUL done pulse width", {63'd0, done0}, 64'd0);
        @(posedge clk); #1;

        run_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "MULH");
        run_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "MULHU");
        run_op(0, 3'd2, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, 33, "MULHSU");
        run_op(0, 3'd5, 64'd100, 64'd7, 64'd14, 33, "DIVU");
        run_op(0, 3'd7, 64'd100, 64'd7, 64'd2, 33, "REMU");
        run_op(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33, "DIV -7/2");
        run_op(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 33, "REM -7%2");
        run_op(0, 3'd4, 64'd5, 64'd0, 64'hFFFF_FFFF, 1, "DIV by 0");
        run_op(0, 3'd6, 64'd5, 64'd0, 64'd5, 1, "REM by 0");
        run_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "DIV ovf");
        run_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "REM ovf");

        // Flush in cycle 10 of a DIVU, then MUL straight after
        nodone = 1'b1;
        drive(0, 1'b1, 1'b0, 3'd5, 64'd100, 64'd7);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done0) nodone = 1'b0;
            @(posedge clk); #1;
        end
        drive(0, 1'b1, 1'b1, 3'd5, 64'd100, 64'd7);
        @(negedge clk);
        if (done0) nodone = 1'b0;
        check("flush busy in cycle 10", {63'd0, busy0}, 64'd1);
        @(posedge clk); #1;
        check("flush suppresses done", {63'd0, nodone}, 64'd1);
        check("flush busy after", {63'd0, busy0}, 64'd0);
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        run_op(0, 3'd0, 64'd3, 64'd4, 64'd12, 33, "MUL after flush");

        // Async reset in cycle 5 of a DIVU
        drive(0, 1'b1, 1'b0, 3'd5, 64'd100, 64'd7);
        repeat (5) @(posedge clk);
        #1;
        check("busy before reset", {63'd0, busy0}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset done", {63'd0, done0}, 64'd0);
        check("async reset result", {32'd0, r0}, 64'd0);
        check("async reset busy", {63'd0, busy0}, 64'd0);
        drive(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_random(1, 32, 40);
        run_random(2, 64, 40);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
